// File: rtl/alu_pipe_pkg.sv
// alu_pipe_pkg
//   Definitions shared by the ALU pipeline blocks. It holds the default
//   result width, the default result FIFO pointer width, and the
//   result-entry type {carry, result}.
package alu_pipe_pkg;

    localparam int unsigned ALU_DATA_WIDTH = 8;
    localparam int unsigned ALU_ADDR_WIDTH = 3;

    // One ALU result as it is stored in the result FIFO. The carry is the MSB.
    typedef struct packed {
        logic                      carry;
        logic [ALU_DATA_WIDTH-1:0] result;
    } result_entry_t;

endpackage : alu_pipe_pkg

// File: rtl/alu_result_fifo_mem.sv
// alu_result_fifo_mem
//   Storage array for alu_result_fifo. Writes are synchronous and reads are
//   asynchronous. The array has no reset.
//   Ports:
//     clk    - write clock
//     we     - write enable
//     waddr  - write address
//     wdata  - write data {carry, result}
//     raddr  - read address
//     rdata  - read data, combinational from raddr
module alu_result_fifo_mem
    import alu_pipe_pkg::*;
#(
    parameter int unsigned data_width = ALU_DATA_WIDTH,
    parameter int unsigned addr_width = ALU_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [addr_width-1:0] waddr,
    input  logic [data_width:0]   wdata,
    input  logic [addr_width-1:0] raddr,
    output logic [data_width:0]   rdata
);

    logic [data_width:0] mem_array [2**addr_width];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_array[waddr] <= wdata;
        end
    end

    assign rdata = mem_array[raddr];

endmodule : alu_result_fifo_mem

// File: rtl/alu_result_fifo.sv
// alu_result_fifo
//   FIFO that buffers ALU results {carry, result} between the ALU stage and
//   its consumer, using a valid/ready handshake on both sides. A write made
//   while the FIFO is full is dropped, and the drop sets the sticky overflow
//   flag.
//   Optional feature: ALU_RESULT_FIFO_STATS_EN adds drop_cnt, a saturating
//   8-bit count of dropped writes.
//   Ports:
//     clk, rst       - clock and asynchronous active-high reset
//     clr            - synchronous flush; clears the pointers, count and overflow
//     in_valid/in_q/in_c/in_ready     - write side
//     out_valid/out_ready/out_q/out_c - read side; the head entry is shown
//                                       combinationally
//     count, full, empty - occupancy
//     overflow       - sticky; set when a write is attempted while full
//     drop_cnt       - (STATS_EN only) count of dropped writes
module alu_result_fifo
    import alu_pipe_pkg::*;
#(
    parameter int unsigned data_width = ALU_DATA_WIDTH,
    parameter int unsigned addr_width = ALU_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  in_valid,
    input  logic [data_width-1:0] in_q,
    input  logic                  in_c,
    output logic                  in_ready,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [data_width-1:0] out_q,
    output logic                  out_c,
    output logic [addr_width:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic                  overflow
`ifdef ALU_RESULT_FIFO_STATS_EN
    ,
    output logic [7:0]            drop_cnt
`endif
);

    localparam logic [addr_width:0] depth_c = {1'b1, {addr_width{1'b0}}};

    logic [addr_width-1:0] wr_ptr;
    logic [addr_width-1:0] rd_ptr;
    logic                  wr_en;
    logic                  rd_en;
    logic [data_width:0]   rd_entry;

    assign full      = (count == depth_c);
    assign empty     = (count == '0);
    assign in_ready  = !full;
    assign out_valid = !empty;

    // Handshake decisions come from the occupancy before the edge. A read that
    // happens in the same cycle does not free space for a write.
    assign wr_en = in_valid && in_ready;
    assign rd_en = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (clr) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (in_valid && full) begin
                overflow <= 1'b1;
            end
        end
    end

`ifdef ALU_RESULT_FIFO_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (clr) begin
            drop_cnt <= '0;
        end else if (in_valid && full && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + 1'b1;
        end
    end
`endif

    // A flush wins over a write in the same cycle, so that write is not stored.
    alu_result_fifo_mem #(
        .data_width (data_width),
        .addr_width (addr_width)
    ) u_mem (
        .clk   (clk),
        .we    (wr_en && !clr),
        .waddr (wr_ptr),
        .wdata ({in_c, in_q}),
        .raddr (rd_ptr),
        .rdata (rd_entry)
    );

    assign out_c = rd_entry[data_width];
    assign out_q = rd_entry[data_width-1:0];

endmodule : alu_result_fifo

// File: tb/tb_alu_result_fifo.sv
// tb_alu_result_fifo
//   Self-checking bench for alu_result_fifo. A queue of result entries models
//   the FIFO contents. Entries are pushed when a write should be accepted and
//   popped and compared when a read should be accepted.
module tb_alu_result_fifo;
    import alu_pipe_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       clr = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_q = '0;
    logic       in_c = 1'b0;
    logic       in_ready;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_q;
    logic       out_c;
    logic [3:0] count;
    logic       full;
    logic       empty;
    logic       overflow;
`ifdef ALU_RESULT_FIFO_STATS_EN
    logic [7:0] drop_cnt;
`endif

    alu_result_fifo #(
        .data_width (8),
        .addr_width (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_q      (in_q),
        .in_c      (in_c),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_q     (out_q),
        .out_c     (out_c),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow)
`ifdef ALU_RESULT_FIFO_STATS_EN
        ,
        .drop_cnt  (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    result_entry_t sb[$];
    bit            m_ovf;
    int            m_drop;
    int            n_cmp;
    int            n_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Checks the occupancy flags, the overflow flag and the visible head entry
    // against the model.
    task automatic check_state();
        check("count", 32'(count), 32'(sb.size()));
        check("empty", 32'(empty), 32'(sb.size() == 0));
        check("full", 32'(full), 32'(sb.size() == 8));
        check("out_valid", 32'(out_valid), 32'(sb.size() != 0));
        check("in_ready", 32'(in_ready), 32'(sb.size() != 8));
        check("overflow", 32'(overflow), 32'(m_ovf));
`ifdef ALU_RESULT_FIFO_STATS_EN
        check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
`endif
        if (sb.size() != 0) begin
            check("head_q", 32'(out_q), 32'(sb[0].result));
            check("head_c", 32'(out_c), 32'(sb[0].carry));
        end
    endtask

    // Runs one clock cycle. Inputs are driven 1 time unit after the rising edge.
    task automatic step(input logic v, input logic [7:0] q, input logic c, input logic rdy);
        bit wr;
        bit rd;
        result_entry_t e;
        in_valid  = v;
        in_q      = q;
        in_c      = c;
        out_ready = rdy;
        #1;
        wr = v && (sb.size() < 8);
        rd = rdy && (sb.size() > 0);
        if (rd) begin
            check("pop_q", 32'(out_q), 32'(sb[0].result));
            check("pop_c", 32'(out_c), 32'(sb[0].carry));
        end
        @(posedge clk);
        #1;
        if (rd) void'(sb.pop_front());
        if (wr) begin
            e.carry  = c;
            e.result = q;
            sb.push_back(e);
        end
        if (v && !wr) begin
            m_ovf = 1'b1;
            if (m_drop < 255) m_drop++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check_state();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        m_ovf  = 1'b0;
        m_drop = 0;
        n_cmp  = 0;
        n_err  = 0;

        // Asynchronous reset: the outputs must settle before any clock edge.
        #2 rst = 1'b1;
        #1;
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Two writes with no read, then pop both.
        step(1'b1, 8'h5A, 1'b1, 1'b0);
        step(1'b1, 8'hFF, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        // A read request while empty must be ignored.
        step(1'b0, 8'h00, 1'b0, 1'b1);

        // Fill the FIFO, make one dropped write, then read while full with a write pending.
        for (int i = 0; i < 8; i++) step(1'b1, 8'(i), 1'(i), 1'b0);
        step(1'b1, 8'h08, 1'b0, 1'b0);
        step(1'b1, 8'h09, 1'b1, 1'b1);
        for (int i = 0; i < 7; i++) step(1'b0, 8'h00, 1'b0, 1'b1);

        // Flush with 4 entries stored and a write arriving in the same cycle.
        for (int i = 0; i < 4; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
        clr      = 1'b1;
        in_valid = 1'b1;
        in_q     = 8'hEE;
        in_c     = 1'b1;
        @(posedge clk);
        #1;
        clr      = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        m_ovf  = 1'b0;
        m_drop = 0;
        check_state();
        step(1'b1, 8'h11, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1);

        // Steady stream of 20 writes with the consumer always ready.
        for (int i = 0; i < 20; i++) step(1'b1, 8'(8'h20 + i), 1'(i % 3 == 0), 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b1);

        // Reset in the middle of a cycle with 3 entries stored.
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h70 + i), 1'b1, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("midrst_count", 32'(count), 32'd0);
        check("midrst_empty", 32'(empty), 32'd1);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        #1 rst = 1'b0;
        sb.delete();
        m_ovf  = 1'b0;
        m_drop = 0;
        @(posedge clk);
        #1;
        check_state();
        step(1'b1, 8'h99, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1);

        // Random traffic.
        for (int i = 0; i < 60; i++) begin
            step(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom),
                 1'($urandom_range(0, 2) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_alu_result_fifo

// File: doc/alu_result_fifo.md
ALU_RESULT_FIFO -- requirements
Module: alu_result_fifo

Interface
REQ-001 Parameter data_width, default 8: width of the ALU result word.
REQ-002 Parameter addr_width, default 3: pointer width; depth = 2^addr_width (8 entries).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 clr  input  1  synchronous flush; empties the FIFO and clears the overflow flag.
REQ-006 in_valid  input  1  the ALU result on in_q/in_c is valid this cycle.
REQ-007 in_q  input  data_width  ALU result (q_out of the ALU stage).
REQ-008 in_c  input  1  ALU carry (c_out of the ALU stage).
REQ-009 in_ready  output  1  FIFO can accept a write this cycle.
REQ-010 out_valid  output  1  head entry is available.
REQ-011 out_ready  input  1  consumer accepts the head entry this cycle.
REQ-012 out_q  output  data_width  head entry result.
REQ-013 out_c  output  1  head entry carry.
REQ-014 count  output  addr_width+1  occupancy, 0..2^addr_width.
REQ-015 full, empty  output  1 each  occupancy flags.
REQ-016 overflow  output  1  sticky flag: a write was attempted while full.

Function
REQ-017 in_ready SHALL equal !full, combinationally; out_valid SHALL equal !empty.
REQ-018 Write accepted when in_valid && in_ready: {in_c,in_q} stored at wr_ptr; wr_ptr increments.
REQ-019 Read accepted when out_valid && out_ready: rd_ptr increments; out_q/out_c SHALL reflect the entry at rd_ptr combinationally.
REQ-020 Latency: an entry written at edge N SHALL be visible on out_valid/out_q after edge N; no fall-through in the same cycle.
REQ-021 Pointers SHALL wrap from 2^addr_width-1 to 0.
REQ-022 Simultaneous accepted write and read: count unchanged, both pointers advance.
REQ-023 Full: in_valid dropped even if a read is accepted the same cycle; overflow SHALL set at the next edge and hold.
REQ-024 Empty: out_ready ignored; rd_ptr and count unchanged.
REQ-025 clr SHALL take priority over writes and reads in that cycle: pointers, count and overflow go to 0.
REQ-026 full = (count == 2^addr_width); empty = (count == 0).

Reset
REQ-027 On rst assertion, without waiting for clk: wr_ptr, rd_ptr, count = 0, overflow = 0, hence out_valid = 0, empty = 1, full = 0, in_ready = 1.
REQ-028 Storage array contents SHALL NOT be reset; out_q/out_c are don't-care while out_valid = 0.
REQ-029 Reset mid-operation SHALL discard all stored entries.

Configuration
REQ-030 Macro ALU_RESULT_FIFO_STATS_EN: when defined, add output drop_cnt (8 bits), counting dropped writes and saturating at 255; cleared by rst and clr.
REQ-031 Without ALU_RESULT_FIFO_STATS_EN: no drop_cnt port and no counter logic; all other behaviour identical.

Structure
REQ-032 Shared package alu_pipe_pkg SHALL hold the default data_width (8) and addr_width (3), and a result-entry type {carry, result}.
REQ-033 Storage SHALL be a sub-module alu_result_fifo_mem: synchronous write, asynchronous read, no reset. Pointer, count and flag logic SHALL stay in alu_result_fifo.

Verification
REQ-034 rst pulse mid-cycle with 3 entries stored -> count = 0, empty = 1, out_valid = 0 immediately, before the next clk edge.
REQ-035 Write 0x5A/c=1, then 0xFF/c=0, with out_ready = 0 -> count = 2, and out_q = 0x5A, out_c = 1 one cycle after the first write; pop -> out_q = 0xFF.
REQ-036 Write 8 entries 0x00..0x07 -> full = 1, in_ready = 0. A 9th write of 0x08 -> dropped, overflow = 1, drop_cnt = 1 if STATS_EN. Drain -> 0x00..0x07 in order.
REQ-037 Full FIFO, in_valid = 1 and out_ready = 1 in the same cycle -> read accepted, write dropped, count = 7, overflow = 1.
REQ-038 Steady stream of 20 writes with out_ready = 1 -> count stays 1, pointers wrap twice, and the output sequence equals the input sequence.
REQ-039 clr with 4 entries stored and in_valid = 1 in the same cycle -> count = 0, overflow = 0, and the write is not stored.
